// File: rtl/fi_pkg.sv
// ============================================================================
// Module  : fi_pkg
// Brief   : Shared state encoding and helpers for the fault-injection campaign.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package fi_pkg;

  localparam int unsigned FI_NUM_STATES = 8;
  localparam int unsigned FI_STATE_W    = 3;

  typedef enum logic [FI_STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_RESTORE = 3'd2,
    ST_INJECT  = 3'd3,
    ST_RUN     = 3'd4,
    ST_OBSERVE = 3'd5,
    ST_REPORT  = 3'd6,
    ST_DONE    = 3'd7
  } fi_state_e;

  function automatic logic fi_sel_in_range(input int unsigned sel,
                                           input int unsigned num_sig);
    return sel < num_sig;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fi_run_counter.sv
// ============================================================================
// Module  : fi_run_counter
// Brief   : Run-length counter; flags the last cycle of an enabled run.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module fi_run_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Terminal count fires on the final cycle so the caller can leave on time.
  assign tc_o = en_i && (count_q == (limit_i - CNT_W'(1)));

endmodule

`default_nettype wire

// File: rtl/fi_campaign_ctrl.sv
// ============================================================================
// Module  : fi_campaign_ctrl
// Brief   : Sequences restore / inject / run / observe for each campaign entry.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module fi_campaign_ctrl
  import fi_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned SEL_W   = 8,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned NUM_SIG = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cfg_case_num,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [SEL_W-1:0]  req_sel,
  input  logic [DATA_W-1:0] req_mask,
  input  logic              req_last,
  input  logic [DATA_W-1:0] golden_state,
  input  logic [DATA_W-1:0] golden_next,
  input  logic [DATA_W-1:0] dut_state,
  output logic              restore_en,
  output logic              inject_en,
  output logic [SEL_W-1:0]  inject_sel,
  output logic [DATA_W-1:0] inject_mask,
  output logic              dut_clk_en,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [SEL_W-1:0]  res_sel,
  output logic [DATA_W-1:0] res_mask,
  output logic [DATA_W-1:0] res_diff,
  output logic              res_bad_sel,
  output logic [CNT_W-1:0]  inj_count,
  output logic              busy,
  output logic              done
);

  fi_state_e         state_q;
  logic [CNT_W-1:0]  case_num_q;
  logic [SEL_W-1:0]  sel_q;
  logic [DATA_W-1:0] mask_q;
  logic              last_q;
  logic              bad_sel_q;
  logic              req_ready_q;
  logic              restore_en_q;
  logic              inject_en_q;
  logic [SEL_W-1:0]  inject_sel_q;
  logic [DATA_W-1:0] inject_mask_q;
  logic              dut_clk_en_q;
  logic              res_valid_q;
  logic [SEL_W-1:0]  res_sel_q;
  logic [DATA_W-1:0] res_mask_q;
  logic [DATA_W-1:0] res_diff_q;
  logic              res_bad_sel_q;
  logic [CNT_W-1:0]  inj_count_q;
  logic              done_q;

  logic              sel_ok;
  logic              run_tc;
  logic              unused_golden;

  // The golden restore value is routed to the target by the harness, not here.
  assign unused_golden = ^golden_state;

  assign sel_ok = fi_sel_in_range(32'(sel_q), NUM_SIG);

  fi_run_counter #(
    .CNT_W (CNT_W)
  ) u_run_counter (
    .clk     (clk),
    .n_rst   (n_rst),
    .load_i  (state_q == ST_INJECT),
    .en_i    (state_q == ST_RUN),
    .limit_i (case_num_q),
    .tc_o    (run_tc)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= ST_IDLE;
      case_num_q    <= '0;
      sel_q         <= '0;
      mask_q        <= '0;
      last_q        <= 1'b0;
      bad_sel_q     <= 1'b0;
      req_ready_q   <= 1'b0;
      restore_en_q  <= 1'b0;
      inject_en_q   <= 1'b0;
      inject_sel_q  <= '0;
      inject_mask_q <= '0;
      dut_clk_en_q  <= 1'b0;
      res_valid_q   <= 1'b0;
      res_sel_q     <= '0;
      res_mask_q    <= '0;
      res_diff_q    <= '0;
      res_bad_sel_q <= 1'b0;
      inj_count_q   <= '0;
      done_q        <= 1'b0;
    end else begin
      // Strobes are single-cycle by default; each state re-arms what it needs.
      restore_en_q  <= 1'b0;
      inject_en_q   <= 1'b0;
      inject_sel_q  <= '0;
      inject_mask_q <= '0;
      dut_clk_en_q  <= 1'b0;
      done_q        <= 1'b0;

      if (abort) begin
        state_q     <= ST_IDLE;
        req_ready_q <= 1'b0;
        res_valid_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start) begin
              state_q     <= ST_FETCH;
              inj_count_q <= '0;
              case_num_q  <= cfg_case_num;
              req_ready_q <= 1'b1;
            end
          end

          ST_FETCH: begin
            if (req_valid) begin
              state_q      <= ST_RESTORE;
              sel_q        <= req_sel;
              mask_q       <= req_mask;
              last_q       <= req_last;
              bad_sel_q    <= 1'b0;
              req_ready_q  <= 1'b0;
              restore_en_q <= 1'b1;
            end
          end

          ST_RESTORE: begin
            state_q   <= ST_INJECT;
            bad_sel_q <= !sel_ok;
            if (sel_ok) begin
              inject_en_q   <= 1'b1;
              inject_sel_q  <= sel_q;
              inject_mask_q <= mask_q;
            end
          end

          ST_INJECT: begin
            if (case_num_q != '0) begin
              state_q      <= ST_RUN;
              dut_clk_en_q <= 1'b1;
            end else begin
              state_q <= ST_OBSERVE;
            end
          end

          ST_RUN: begin
            if (run_tc) begin
              state_q <= ST_OBSERVE;
            end else begin
              dut_clk_en_q <= 1'b1;
            end
          end

          ST_OBSERVE: begin
            state_q       <= ST_REPORT;
            res_valid_q   <= 1'b1;
            res_diff_q    <= golden_next ^ dut_state;
            res_sel_q     <= sel_q;
            res_mask_q    <= mask_q;
            res_bad_sel_q <= bad_sel_q;
          end

          ST_REPORT: begin
            if (res_ready) begin
              res_valid_q <= 1'b0;
              inj_count_q <= inj_count_q + CNT_W'(1);
              if (last_q) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q     <= ST_FETCH;
                req_ready_q <= 1'b1;
              end
            end
          end

          ST_DONE: begin
            state_q <= ST_IDLE;
          end

          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign req_ready   = req_ready_q;
  assign restore_en  = restore_en_q;
  assign inject_en   = inject_en_q;
  assign inject_sel  = inject_sel_q;
  assign inject_mask = inject_mask_q;
  assign dut_clk_en  = dut_clk_en_q;
  assign res_valid   = res_valid_q;
  assign res_sel     = res_sel_q;
  assign res_mask    = res_mask_q;
  assign res_diff    = res_diff_q;
  assign res_bad_sel = res_bad_sel_q;
  assign inj_count   = inj_count_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_fi_campaign_ctrl.sv
// ============================================================================
// Module  : tb_fi_campaign_ctrl
// Brief   : Scenario-driven self-checking bench for fi_campaign_ctrl.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_fi_campaign_ctrl;

  localparam int unsigned DATA_W  = 64;
  localparam int unsigned SEL_W   = 8;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned NUM_SIG = 4;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CNT_W-1:0]  cfg_case_num = '0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [SEL_W-1:0]  req_sel = '0;
  logic [DATA_W-1:0] req_mask = '0;
  logic              req_last = 1'b0;
  logic [DATA_W-1:0] golden_state = '0;
  logic [DATA_W-1:0] golden_next = '0;
  logic [DATA_W-1:0] dut_state = '0;
  logic              restore_en;
  logic              inject_en;
  logic [SEL_W-1:0]  inject_sel;
  logic [DATA_W-1:0] inject_mask;
  logic              dut_clk_en;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [SEL_W-1:0]  res_sel;
  logic [DATA_W-1:0] res_mask;
  logic [DATA_W-1:0] res_diff;
  logic              res_bad_sel;
  logic [CNT_W-1:0]  inj_count;
  logic              busy;
  logic              done;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] diff;
    logic              bad;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  fi_campaign_ctrl #(
    .DATA_W  (DATA_W),
    .SEL_W   (SEL_W),
    .CNT_W   (CNT_W),
    .NUM_SIG (NUM_SIG)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .abort        (abort),
    .cfg_case_num (cfg_case_num),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_sel      (req_sel),
    .req_mask     (req_mask),
    .req_last     (req_last),
    .golden_state (golden_state),
    .golden_next  (golden_next),
    .dut_state    (dut_state),
    .restore_en   (restore_en),
    .inject_en    (inject_en),
    .inject_sel   (inject_sel),
    .inject_mask  (inject_mask),
    .dut_clk_en   (dut_clk_en),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_sel      (res_sel),
    .res_mask     (res_mask),
    .res_diff     (res_diff),
    .res_bad_sel  (res_bad_sel),
    .inj_count    (inj_count),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_campaign(input logic [CNT_W-1:0] n);
    cfg_case_num = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offers one entry, waits for the accept edge and records the expected result.
  task automatic accept_entry(input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] mask,
                              input logic last, input logic [DATA_W-1:0] flip);
    int   w;
    exp_t e;
    w = 0;
    req_sel      = sel;
    req_mask     = mask;
    req_last     = last;
    golden_state = {$urandom, $urandom};
    golden_next  = {$urandom, $urandom};
    dut_state    = golden_next ^ flip;
    req_valid    = 1'b1;
    while (!req_ready && w < 20) begin
      tick();
      w++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout req_ready=%0b required 1", req_ready);
      req_valid = 1'b0;
    end else begin
      e.sel  = sel;
      e.mask = mask;
      e.diff = flip;
      e.bad  = (sel >= NUM_SIG);
      sb_q.push_back(e);
      tick();
      req_valid = 1'b0;
    end
  endtask

  // Follows an accepted entry to its result, stalls, and completes the handshake.
  task automatic finish_entry(input int exp_lat, input int exp_clk, input int stall,
                              input logic last);
    int   lat, nclk, ninj, nrst, excl, badinj;
    exp_t e;
    lat = 0; nclk = 0; ninj = 0; nrst = 0; excl = 0; badinj = 0;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty size=0 required >0");
      return;
    end
    e = sb_q[0];
    while (!res_valid && lat < 200) begin
      nclk += int'(dut_clk_en);
      ninj += int'(inject_en);
      nrst += int'(restore_en);
      if (int'(restore_en) + int'(inject_en) + int'(dut_clk_en) > 1) excl++;
      if (inject_en && (inject_sel !== e.sel || inject_mask !== e.mask)) badinj++;
      tick();
      lat++;
    end
    checks++;
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL result_timeout res_valid=%0b required 1", res_valid);
      return;
    end
    e = sb_q.pop_front();
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL latency got %0d required %0d", lat, exp_lat);
    end
    checks++;
    if (nclk !== exp_clk || nrst !== 1 || ninj !== (e.bad ? 0 : 1)) begin
      errors++;
      $display("FAIL strobe_counts clk=%0d rst=%0d inj=%0d required clk=%0d rst=1 inj=%0d",
               nclk, nrst, ninj, exp_clk, e.bad ? 0 : 1);
    end
    checks++;
    if (excl !== 0 || badinj !== 0) begin
      errors++;
      $display("FAIL strobe_exclusive overlap=%0d badinj=%0d required 0 0", excl, badinj);
    end
    checks++;
    if (res_diff !== e.diff) begin
      errors++;
      $display("FAIL res_diff got %h required %h", res_diff, e.diff);
    end
    checks++;
    if (res_sel !== e.sel || res_mask !== e.mask || res_bad_sel !== e.bad) begin
      errors++;
      $display("FAIL res_echo got sel=%0d mask=%h bad=%0b required sel=%0d mask=%h bad=%0b",
               res_sel, res_mask, res_bad_sel, e.sel, e.mask, e.bad);
    end
    for (int i = 0; i < stall; i++) begin
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_diff !== e.diff || res_sel !== e.sel ||
          res_mask !== e.mask || res_bad_sel !== e.bad) begin
        errors++;
        $display("FAIL stall_stable cycle=%0d valid=%0b diff=%h required valid=1 diff=%h",
                 i, res_valid, res_diff, e.diff);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (done !== last || res_valid !== 1'b0 || req_ready !== !last) begin
      errors++;
      $display("FAIL post_handshake done=%0b valid=%0b ready=%0b required done=%0b valid=0 ready=%0b",
               done, res_valid, req_ready, last, !last);
    end
    if (last) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_single done=%0b busy=%0b required 0 0", done, busy);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({req_ready, restore_en, inject_en, dut_clk_en, res_valid, res_bad_sel, busy, done} !== 8'b0 ||
        inj_count !== '0 || res_diff !== '0 || res_sel !== '0 || res_mask !== '0 ||
        inject_sel !== '0 || inject_mask !== '0) begin
      errors++;
      $display("FAIL %s ready=%0b valid=%0b busy=%0b done=%0b cnt=%0d diff=%h required all 0",
               tag, req_ready, res_valid, busy, done, inj_count, res_diff);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    tick();
    tick();
    check_all_zero("reset_state");
    n_rst = 1'b1;
    tick();
    check_all_zero("after_reset_release");
  endtask

  task automatic test_single();
    start_campaign(5);
    accept_entry(0, 64'h1, 1'b1, 64'h1);
    finish_entry(8, 5, 0, 1'b1);
    checks++;
    if (inj_count !== 32'd1) begin
      errors++;
      $display("FAIL single_inj_count got %0d required 1", inj_count);
    end
  endtask

  task automatic test_back_to_back();
    start_campaign(2);
    accept_entry(1, {$urandom, $urandom}, 1'b0, {$urandom, $urandom});
    finish_entry(5, 2, 0, 1'b0);
    accept_entry(3, {$urandom, $urandom}, 1'b0, {$urandom, $urandom});
    finish_entry(5, 2, 4, 1'b0);
    accept_entry(2, {$urandom, $urandom}, 1'b1, 64'h8000_0000_0000_0001);
    finish_entry(5, 2, 1, 1'b1);
    checks++;
    if (inj_count !== 32'd3) begin
      errors++;
      $display("FAIL b2b_inj_count got %0d required 3", inj_count);
    end
  endtask

  task automatic test_zero_case();
    start_campaign(0);
    accept_entry(2, 64'hF0F0, 1'b1, 64'h0);
    finish_entry(3, 0, 0, 1'b1);
  endtask

  task automatic test_bad_sel();
    start_campaign(1);
    accept_entry(SEL_W'(NUM_SIG), 64'hDEAD_BEEF, 1'b1, 64'h40);
    finish_entry(4, 1, 0, 1'b1);
  endtask

  task automatic test_abort();
    int nclk, w, dones, busys;
    nclk = 0; w = 0; dones = 0; busys = 0;
    start_campaign(5);
    accept_entry(0, 64'h2, 1'b0, 64'h2);
    finish_entry(8, 5, 0, 1'b0);
    accept_entry(1, 64'h4, 1'b0, 64'h4);
    while (w < 20) begin
      nclk += int'(dut_clk_en);
      if (nclk == 2) break;
      tick();
      w++;
    end
    checks++;
    if (nclk !== 2) begin
      errors++;
      $display("FAIL abort_reach_run clk_cycles=%0d required 2", nclk);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sb_q.delete();
    checks++;
    if (busy !== 1'b0 || dut_clk_en !== 1'b0 || res_valid !== 1'b0 || req_ready !== 1'b0 ||
        done !== 1'b0 || inj_count !== 32'd1) begin
      errors++;
      $display("FAIL abort_state busy=%0b clk_en=%0b valid=%0b done=%0b cnt=%0d required 0 0 0 0 1",
               busy, dut_clk_en, res_valid, done, inj_count);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      dones += int'(done);
      busys += int'(busy);
    end
    checks++;
    if (dones !== 0 || busys !== 0) begin
      errors++;
      $display("FAIL abort_quiet done_cycles=%0d busy_cycles=%0d required 0 0", dones, busys);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    w = 0;
    start_campaign(3);
    accept_entry(2, 64'h10, 1'b1, 64'h10);
    while (!res_valid && w < 20) begin
      tick();
      w++;
    end
    checks++;
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_reach_report res_valid=%0b required 1", res_valid);
    end
    #2;
    n_rst = 1'b0;
    #1;
    check_all_zero("reset_mid_outputs");
    sb_q.delete();
    tick();
    tick();
    n_rst = 1'b1;
    tick();
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_done done=%0b busy=%0b required 0 0", done, busy);
    end
    start_campaign(1);
    accept_entry(0, 64'h3, 1'b1, 64'h5);
    finish_entry(4, 1, 0, 1'b1);
    checks++;
    if (inj_count !== 32'd1) begin
      errors++;
      $display("FAIL rstmid_fresh_count got %0d required 1", inj_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_case();
    test_bad_sel();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fi_campaign_ctrl.md
FI_CAMPAIGN_CTRL -- requirements
Module: fi_campaign_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning the width of the target state vector, mask and diff.
REQ-002 The block SHALL have parameter SEL_W, default 8, meaning the width of the signal selector.
REQ-003 The block SHALL have parameter CNT_W, default 32, meaning the width of the run-length and injection counters.
REQ-004 The block SHALL have parameter NUM_SIG, default 1, meaning the number of injectable signals; valid selectors are 0..NUM_SIG-1.
REQ-005 Ports SHALL be, as name direction width meaning:
  clk  in  1  single clock; all logic on posedge
  n_rst  in  1  asynchronous active-low reset
  start  in  1  campaign start pulse
  abort  in  1  synchronous abort
  cfg_case_num  in  CNT_W  DUT cycles per injection run
  req_valid  in  1  injection entry valid
  req_ready  out  1  entry accepted when valid&ready
  req_sel  in  SEL_W  target signal index
  req_mask  in  DATA_W  bit-flip mask
  req_last  in  1  final entry of campaign
  golden_state  in  DATA_W  golden value to restore
  golden_next  in  DATA_W  expected post-run value
  dut_state  in  DATA_W  observed DUT value
  restore_en  out  1  load golden_state into DUT
  inject_en  out  1  XOR inject_mask into selected signal
  inject_sel  out  SEL_W  selected signal
  inject_mask  out  DATA_W  mask to apply
  dut_clk_en  out  1  advance DUT one cycle
  res_valid  out  1  result valid
  res_ready  in  1  result accepted
  res_sel, res_mask  out  SEL_W, DATA_W  echo of entry
  res_diff  out  DATA_W  golden_next ^ dut_state
  res_bad_sel  out  1  selector out of range
  inj_count  out  CNT_W  completed injections
  busy  out  1  state != IDLE
  done  out  1  one-cycle completion pulse

Function
REQ-006 FSM states SHALL be IDLE, FETCH, RESTORE, INJECT, RUN, OBSERVE, REPORT, DONE.
REQ-007 IDLE: start=1 -> FETCH, clear inj_count, latch cfg_case_num; start in any other state SHALL be ignored.
REQ-008 FETCH: req_ready=1; on req_valid latch sel, mask, last -> RESTORE; req_ready=0 in all other states.
REQ-009 RESTORE: restore_en=1 for exactly one cycle -> INJECT.
REQ-010 INJECT: inject_en=1 for one cycle with latched sel/mask, unless sel>=NUM_SIG (inject_en=0, bad_sel flag set); run counter cleared; -> RUN if case_num>0, else OBSERVE.
REQ-011 RUN: dut_clk_en=1 every cycle; exactly case_num cycles, then -> OBSERVE.
REQ-012 OBSERVE: register res_diff = golden_next ^ dut_state in one cycle -> REPORT.
REQ-013 REPORT: res_valid=1 with stable res_* until res_ready; on handshake increment inj_count (wrap modulo 2^CNT_W) -> DONE if last, else FETCH.
REQ-014 DONE: done=1 for one cycle -> IDLE.
REQ-015 restore_en, inject_en, dut_clk_en SHALL be mutually exclusive.
REQ-016 abort=1 SHALL force IDLE next cycle from any state, deassert all strobes and res_valid, retain inj_count, and not pulse done; abort has priority over start and all handshakes.
REQ-017 Latency from accepted entry to res_valid SHALL be case_num+3 cycles.

Reset
REQ-018 n_rst=0 SHALL asynchronously force IDLE and zero every output and internal register.
REQ-019 Reset mid-campaign SHALL discard the pending entry and result; no done pulse follows.

Structure
REQ-020 State enum and state-count constants SHALL reside in shared package fi_pkg.
REQ-021 The run-length counter SHALL be a sub-module fi_run_counter (load, enable, terminal-count out).

Verification
REQ-022 case_num=5, one entry sel=0 mask=0x1 last=1, dut_state=golden_next^0x1 -> res_diff=0x1 at cycle 8 after accept, done one cycle after res_ready.
REQ-023 Three entries, res_ready low 4 cycles on second -> res_* stable while stalled, inj_count=3, single done.
REQ-024 case_num=0 -> zero dut_clk_en cycles, res_valid 3 cycles after accept.
REQ-025 sel=NUM_SIG -> inject_en never asserted, res_bad_sel=1.
REQ-026 abort during RUN cycle 2 -> IDLE next cycle, dut_clk_en=0, no done, busy=0.
REQ-027 n_rst low in REPORT -> all outputs 0 immediately; start afterwards runs a fresh campaign.
